// File: rtl/risc16_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : risc16_pkg
//  Purpose  : Shared RiSC-16 definitions: word length, opcodes, instruction
//             field positions and the NOP encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package risc16_pkg;

    localparam int c_WORD_LEN = 16;

    // Major opcodes, instruction bits [15:13]
    localparam logic [2:0] c_OP_ADD  = 3'd0;
    localparam logic [2:0] c_OP_ADDI = 3'd1;
    localparam logic [2:0] c_OP_NAND = 3'd2;
    localparam logic [2:0] c_OP_LUI  = 3'd3;
    localparam logic [2:0] c_OP_SW   = 3'd4;
    localparam logic [2:0] c_OP_LW   = 3'd5;
    localparam logic [2:0] c_OP_BEQ  = 3'd6;
    localparam logic [2:0] c_OP_JALR = 3'd7;

    // Field bit positions
    localparam int c_OP_MSB    = 15;
    localparam int c_OP_LSB    = 13;
    localparam int c_RA_MSB    = 12;
    localparam int c_RA_LSB    = 10;
    localparam int c_RB_MSB    = 9;
    localparam int c_RB_LSB    = 7;
    localparam int c_RC_MSB    = 2;
    localparam int c_RC_LSB    = 0;
    localparam int c_IMM7_MSB  = 6;
    localparam int c_IMM10_MSB = 9;

    localparam logic [c_WORD_LEN-1:0] c_NOP = 16'h0000;

    function automatic logic [2:0] get_opcode(input logic [c_WORD_LEN-1:0] inst);
        return inst[c_OP_MSB:c_OP_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO with flush. Holds instruction data only; the
//             matching addresses are implied by the consumer's head pointer.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int p_WIDTH = 16,
    parameter int p_DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [p_WIDTH-1:0]       i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [p_WIDTH-1:0]       o_head,
    output logic [$clog2(p_DEPTH):0] o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int c_PTR_W = $clog2(p_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [p_WIDTH-1:0] r_mem [p_DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Pointer and occupancy bookkeeping; a flush wins over push and pop
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only observed after it is written
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_CNT_W'(p_DEPTH));

endmodule
`default_nettype wire

// File: rtl/inst_fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_buffer
//  Purpose  : Sequential instruction prefetcher between a variable-latency
//             valid/ready instruction memory and the single-cycle core.
//             Flushes on any PC discontinuity and discards stale responses.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_buffer
    import risc16_pkg::*;
#(
    parameter int p_WORD_LEN = c_WORD_LEN,
    parameter int p_DEPTH    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [p_WORD_LEN-1:0] i_pc,
    input  logic                  i_inst_ack,
    output logic [p_WORD_LEN-1:0] o_inst,
    output logic                  o_inst_valid,
    output logic                  o_imem_req_valid,
    input  logic                  i_imem_req_ready,
    output logic [p_WORD_LEN-1:0] o_imem_req_addr,
    input  logic                  i_imem_rsp_valid,
    input  logic [p_WORD_LEN-1:0] i_imem_rsp_data
);

    localparam int c_CNT_W = $clog2(p_DEPTH) + 1;   // holds 0..p_DEPTH
    localparam int c_SUM_W = c_CNT_W + 2;           // holds the sum of three counters
    localparam logic [c_SUM_W-1:0] c_DEPTH_SUM = c_SUM_W'(p_DEPTH);

    logic [p_WORD_LEN-1:0] r_fetch_pc;
    logic [p_WORD_LEN-1:0] r_expect_pc;
    logic [c_CNT_W-1:0]    r_live;
    logic [c_CNT_W-1:0]    r_drop;
    logic                  r_started;   // low in the first cycle after reset release

    logic [p_WORD_LEN-1:0] w_fifo_head;
    logic [c_CNT_W-1:0]    w_fifo_count;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic [c_SUM_W-1:0]    w_occupancy;
    logic                  w_redirect;
    logic                  w_issue;
    logic                  w_req_fire;
    logic                  w_rsp_drop;
    logic                  w_push;
    logic                  w_pop;

    // Redirect detection, issue gating, response routing and core-side outputs
    always_comb begin
        // Reset release is treated as a discontinuity so fetch starts cleanly
        w_redirect       = !r_started || (i_pc != r_expect_pc);
        // Every FIFO slot is reserved by a queued word or an outstanding request
        w_occupancy      = c_SUM_W'(w_fifo_count) + c_SUM_W'(r_live) + c_SUM_W'(r_drop);
        w_issue          = !w_redirect && (w_occupancy < c_DEPTH_SUM);
        w_req_fire       = w_issue && i_imem_req_ready;
        w_rsp_drop       = i_imem_rsp_valid && (r_drop != '0);
        w_push           = i_imem_rsp_valid && (r_drop == '0) && !w_redirect;
        o_inst_valid     = !w_redirect && !w_fifo_empty;
        w_pop            = i_inst_ack && o_inst_valid;
        o_inst           = o_inst_valid ? w_fifo_head : p_WORD_LEN'(c_NOP);
        o_imem_req_valid = w_issue;
        o_imem_req_addr  = r_fetch_pc;
    end

    // Stream addresses and in-flight request accounting
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_started   <= 1'b0;
            r_fetch_pc  <= '0;
            r_expect_pc <= '0;
            r_live      <= '0;
            r_drop      <= '0;
        end else begin
            r_started <= 1'b1;
            if (w_redirect) begin
                // Everything still in flight now belongs to a dead stream
                r_fetch_pc  <= i_pc;
                r_expect_pc <= i_pc;
                r_live      <= '0;
                r_drop      <= r_drop + r_live - c_CNT_W'(i_imem_rsp_valid);
            end else begin
                if (w_req_fire) r_fetch_pc  <= r_fetch_pc + p_WORD_LEN'(1);
                if (w_pop)      r_expect_pc <= r_expect_pc + p_WORD_LEN'(1);
                r_live <= r_live + c_CNT_W'(w_req_fire) - c_CNT_W'(w_push);
                r_drop <= r_drop - c_CNT_W'(w_rsp_drop);
            end
        end
    end

    sync_fifo #(
        .p_WIDTH (p_WORD_LEN),
        .p_DEPTH (p_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  (i_imem_rsp_data),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .o_head  (w_fifo_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // The issue gate reserves a slot per request, so a push never meets a full FIFO
    a_fifo_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(w_push && w_fifo_full && !w_pop));

endmodule
`default_nettype wire
